d_flipflop_pair: RTL and testbench

- Multi-stage flip-flop synchronizer.
- Brings an asynchronous input (e.g. the UART RX serial line) into the mclk domain so downstream state machines never sample a metastable value.
- Default configuration is a 1-bit, two-stage chain.
- Also provides registered-history edge-detect outputs so consumers need no extra flops.

---
 rtl/d_flipflop_pair.sv | 67 ++++++
 tb/tb_d_flipflop_pair.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/d_flipflop_pair.sv
// Multi-stage synchronizer bringing asynchronous inputs into the mclk domain,
// with registered history and single-cycle rise/fall strobes per bit.

module d_flipflop_pair_lane #(
  parameter int   STAGES  = 2,
  parameter logic RST_BIT = 1'b0
) (
  input  logic mclk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic q_prev
);

  // Plain flop chain; the attribute keeps the tools from retiming or merging it.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      stage  <= {STAGES{RST_BIT}};
      q_prev <= RST_BIT;
    end else begin
      stage  <= {stage[STAGES-2:0], d};
      q_prev <= stage[STAGES-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

module d_flipflop_pair #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_prev,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("d_flipflop_pair: STAGES must be >= 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    d_flipflop_pair_lane #(
      .STAGES  (STAGES),
      .RST_BIT (RESET_VALUE[i])
    ) u_lane (
      .mclk   (mclk),
      .reset  (reset),
      .d      (d[i]),
      .q      (q[i]),
      .q_prev (q_prev[i])
    );
  end

  // q_prev shares the reset value, so no strobe fires on reset release.
  assign q_rise = q & ~q_prev;
  assign q_fall = ~q & q_prev;

endmodule

// File: tb/tb_d_flipflop_pair.sv
// Bench for d_flipflop_pair: three configurations checked against a
// sample-history reference model (q = d as sampled STAGES edges ago).
`timescale 1ns/1ps
module tb_d_flipflop_pair;

  logic       mclk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset;
  logic       d0, d1;
  logic [3:0] d2;
  logic       q0, qp0, qr0, qf0;
  logic       q1, qp1, qr1, qf1;
  logic [3:0] q2, qp2, qr2, qf2;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] RV [3] = '{4'h0, 4'h1, 4'h0};
  localparam int         SG [3] = '{2, 2, 3};

  logic [3:0] hist [3][0:1023];
  int         n = 0;

  always #5 if (clk_run) mclk = ~mclk;

  d_flipflop_pair u0 (
    .mclk(mclk), .reset(reset), .d(d0),
    .q(q0), .q_prev(qp0), .q_rise(qr0), .q_fall(qf0));

  d_flipflop_pair #(.WIDTH(1), .STAGES(2), .RESET_VALUE(1'b1)) u1 (
    .mclk(mclk), .reset(reset), .d(d1),
    .q(q1), .q_prev(qp1), .q_rise(qr1), .q_fall(qf1));

  d_flipflop_pair #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h0)) u2 (
    .mclk(mclk), .reset(reset), .d(d2),
    .q(q2), .q_prev(qp2), .q_rise(qr2), .q_fall(qf2));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of q 'back' edges ago (back=0 -> now), from recorded d samples.
  function automatic logic [3:0] model_q(input int k, input int back);
    int idx;
    idx = n - back - SG[k];
    return (idx >= 0) ? hist[k][idx] : RV[k];
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] eq, ep;
    logic [3:0] oq [3];
    logic [3:0] op [3];
    logic [3:0] orr [3];
    logic [3:0] of [3];
    oq  = '{{3'b0, q0},  {3'b0, q1},  q2};
    op  = '{{3'b0, qp0}, {3'b0, qp1}, qp2};
    orr = '{{3'b0, qr0}, {3'b0, qr1}, qr2};
    of  = '{{3'b0, qf0}, {3'b0, qf1}, qf2};
    for (int k = 0; k < 3; k++) begin
      eq = model_q(k, 0);
      ep = model_q(k, 1);
      chk($sformatf("%s u%0d q", tag, k),      oq[k],  eq);
      chk($sformatf("%s u%0d q_prev", tag, k), op[k],  ep);
      chk($sformatf("%s u%0d q_rise", tag, k), orr[k], eq & ~ep);
      chk($sformatf("%s u%0d q_fall", tag, k), of[k],  ~eq & ep);
    end
  endtask

  // One rising edge: record the sampled inputs, then check just after it.
  task automatic step(input string tag);
    @(posedge mclk);
    if (reset) begin
      hist[0][n] = {3'b0, d0};
      hist[1][n] = {3'b0, d1};
      hist[2][n] = d2;
      n++;
    end
    #1;
    check_all(tag);
    #1;
  endtask

  initial begin
    d0 = 1'b0; d1 = 1'b1; d2 = 4'h0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset with no clock: d toggles, outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      #3;
      d0 = ~d0; d2 = d2 ^ 4'hF;
      #1 check_all("reset_noclk");
    end
    d0 = 1'b0; d2 = 4'h0; d1 = 1'b1;

    #2 reset = 1'b1;
    #2 clk_run = 1'b1;

    step("idle");
    step("idle");
    chk("uart_idle q1", {3'b0, q1}, 4'h1);
    chk("uart_idle q1_fall", {3'b0, qf1}, 4'h0);

    // Rising latency on the default chain.
    d0 = 1'b1;
    step("lat_N");
    chk("lat edgeN q0", {3'b0, q0}, 4'h0);
    step("lat_N1");
    chk("lat edgeN1 q0", {3'b0, q0}, 4'h1);
    chk("lat edgeN1 q_rise", {3'b0, qr0}, 4'h1);
    step("lat_N2");
    chk("lat edgeN2 q_rise", {3'b0, qr0}, 4'h0);
    chk("lat edgeN2 q_prev", {3'b0, qp0}, 4'h1);

    // Falling latency.
    d0 = 1'b0;
    step("fall_M");
    chk("fall edgeM q0", {3'b0, q0}, 4'h1);
    step("fall_M1");
    chk("fall edgeM1 q0", {3'b0, q0}, 4'h0);
    chk("fall edgeM1 q_fall", {3'b0, qf0}, 4'h1);
    chk("fall edgeM1 q_rise", {3'b0, qr0}, 4'h0);
    step("fall_M2");
    chk("fall edgeM2 q_fall", {3'b0, qf0}, 4'h0);
    chk("uart_idle2 q1", {3'b0, q1}, 4'h1);

    // Single-cycle pulse.
    d0 = 1'b1;
    step("pulse_a");
    d0 = 1'b0;
    step("pulse_b");
    chk("pulse rise", {3'b0, qr0}, 4'h1);
    step("pulse_c");
    chk("pulse fall", {3'b0, qf0}, 4'h1);
    chk("pulse q low", {3'b0, q0}, 4'h0);
    step("pulse_d");

    // Randomized traffic on all three instances.
    for (int i = 0; i < 150; i++) begin
      d0 = 1'($urandom);
      d1 = 1'($urandom);
      d2 = 4'($urandom);
      step("rand");
    end

    // Asynchronous reset mid-stream on the wide chain.
    d2 = 4'hA;
    for (int i = 0; i < 4; i++) step("settle");
    chk("mid q2 settled", q2, 4'hA);
    reset = 1'b0;
    #1;
    n = 0;
    check_all("async_rst");
    chk("async_rst q2", q2, 4'h0);
    step("in_reset");
    reset = 1'b1;
    d2 = 4'h5;
    step("rel1");
    step("rel2");
    chk("rel2 q2", q2, 4'h0);
    step("rel3");
    chk("rel3 q2", q2, 4'h5);
    step("rel4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
